dnn_ctrl: RTL and testbench

//  Sequencer for the 2-node dnn datapath. Accepts 7-bit input vectors tagged with node id (0/1), runs each

---
 rtl/dnn_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_dnn_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dnn_ctrl.sv
// Sequencer for the 2-node dnn datapath: per-vector layer-1 pass with per-node ReLU accumulation,
// then a final pass and a result handshake. dnn_state encoding: 0 IDLE, 1 LAYER1, 2 FINAL_OUT.
module dnn_ctrl #(
    parameter int unsigned SAMPLES_PER_NODE = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               x_valid,
    output logic               x_ready,
    input  logic               x_node,
    input  logic signed [6:0]  x_in0,
    input  logic signed [6:0]  x_in1,
    input  logic signed [6:0]  x_in2,
    input  logic signed [6:0]  x_in3,
    input  logic               flush,
    output logic [1:0]         dnn_state,
    output logic signed [6:0]  x0,
    output logic signed [6:0]  x1,
    output logic signed [6:0]  x2,
    output logic signed [6:0]  x3,
    input  logic [12:0]        y4_relu,
    input  logic [12:0]        y5_relu,
    input  logic [12:0]        y6_relu,
    input  logic [12:0]        y7_relu,
    input  logic               out0_n0_ready,
    input  logic               out0_n1_ready,
    input  logic               out1_n0_ready,
    input  logic               out1_n1_ready,
    output logic signed [14:0] y4_n0_aggr,
    output logic signed [14:0] y5_n0_aggr,
    output logic signed [14:0] y6_n0_aggr,
    output logic signed [14:0] y7_n0_aggr,
    output logic signed [14:0] y4_n1_aggr,
    output logic signed [14:0] y5_n1_aggr,
    output logic signed [14:0] y6_n1_aggr,
    output logic signed [14:0] y7_n1_aggr,
    output logic               result_valid,
    input  logic               result_ready,
    output logic               busy
);

    localparam logic [1:0] DNN_IDLE      = 2'd0;
    localparam logic [1:0] DNN_LAYER1    = 2'd1;
    localparam logic [1:0] DNN_FINAL_OUT = 2'd2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_L1    = 3'd1;
    localparam logic [2:0] S_CAPT  = 3'd2;
    localparam logic [2:0] S_FIN   = 3'd3;
    localparam logic [2:0] S_LATCH = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [3:0]  SAMPLES  = 4'(SAMPLES_PER_NODE);
    localparam logic [14:0] AGGR_MAX = 15'd16383;

    // Aggregates are never negative, so the sum is done unsigned and clamped below the sign bit.
    function automatic logic [14:0] sat_add(input logic [14:0] acc, input logic [12:0] val);
        logic [15:0] sum_s;
        sum_s = {1'b0, acc} + {3'b000, val};
        if (sum_s > {1'b0, AGGR_MAX}) begin
            sat_add = AGGR_MAX;
        end else begin
            sat_add = sum_s[14:0];
        end
    endfunction

    function automatic logic [1:0] dnn_of(input logic [2:0] st);
        case (st)
            S_L1, S_CAPT: dnn_of = DNN_LAYER1;
            S_FIN:        dnn_of = DNN_FINAL_OUT;
            default:      dnn_of = DNN_IDLE;
        endcase
    endfunction

    logic [2:0]  state_r;
    logic [2:0]  state_nxt_s;
    logic        take_s;
    logic        node_r;
    logic [3:0]  cnt_r  [2];
    logic [6:0]  x_r    [4];
    logic [14:0] aggr_r [2][4];
    logic [12:0] relu_s [4];
    logic        out_all_s;

    assign relu_s[0] = y4_relu;
    assign relu_s[1] = y5_relu;
    assign relu_s[2] = y6_relu;
    assign relu_s[3] = y7_relu;
    assign out_all_s = out0_n0_ready & out0_n1_ready & out1_n0_ready & out1_n1_ready;

    assign x0 = x_r[0];
    assign x1 = x_r[1];
    assign x2 = x_r[2];
    assign x3 = x_r[3];
    assign y4_n0_aggr = aggr_r[0][0];
    assign y5_n0_aggr = aggr_r[0][1];
    assign y6_n0_aggr = aggr_r[0][2];
    assign y7_n0_aggr = aggr_r[0][3];
    assign y4_n1_aggr = aggr_r[1][0];
    assign y5_n1_aggr = aggr_r[1][1];
    assign y6_n1_aggr = aggr_r[1][2];
    assign y7_n1_aggr = aggr_r[1][3];

    // Upstream ready depends on the offered node's fill level, so it stays combinational.
    always_comb begin
        if (state_r == S_IDLE) begin
            x_ready = (cnt_r[x_node] < SAMPLES);
        end else begin
            x_ready = 1'b0;
        end
    end

    // Next-state logic; a transfer always wins over a flush or an automatic final pass.
    always_comb begin
        state_nxt_s = state_r;
        take_s      = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (x_valid && x_ready) begin
                    state_nxt_s = S_L1;
                    take_s      = 1'b1;
                end else if (flush || (cnt_r[0] == SAMPLES && cnt_r[1] == SAMPLES)) begin
                    state_nxt_s = S_FIN;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_L1:    state_nxt_s = S_CAPT;
            S_CAPT:  state_nxt_s = S_IDLE;
            S_FIN:   state_nxt_s = S_LATCH;
            S_LATCH: begin
                if (out_all_s) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_LATCH;
                end
            end
            S_DONE: begin
                if (result_ready) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_DONE;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State, registered outputs, vector latch and per-node accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            dnn_state    <= DNN_IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            node_r       <= 1'b0;
            for (int n = 0; n < 2; n++) begin
                cnt_r[n] <= 4'd0;
                for (int k = 0; k < 4; k++) aggr_r[n][k] <= 15'd0;
            end
            for (int i = 0; i < 4; i++) x_r[i] <= 7'd0;
        end else begin
            state_r      <= state_nxt_s;
            dnn_state    <= dnn_of(state_nxt_s);
            busy         <= (state_nxt_s != S_IDLE);
            result_valid <= (state_nxt_s == S_DONE);
            if (take_s) begin
                x_r[0] <= x_in0;
                x_r[1] <= x_in1;
                x_r[2] <= x_in2;
                x_r[3] <= x_in3;
                node_r <= x_node;
            end
            if (state_r == S_CAPT) begin
                for (int k = 0; k < 4; k++) aggr_r[node_r][k] <= sat_add(aggr_r[node_r][k], relu_s[k]);
                cnt_r[node_r] <= cnt_r[node_r] + 4'd1;
            end else if (state_r == S_DONE && result_ready) begin
                for (int n = 0; n < 2; n++) begin
                    cnt_r[n] <= 4'd0;
                    for (int k = 0; k < 4; k++) aggr_r[n][k] <= 15'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dnn_ctrl.sv
// Self-checking bench for dnn_ctrl: directed vectors, a transaction-level expectation model
// checked every falling edge, and literal checks pinning the model.
module tb_dnn_ctrl;

    localparam int S = 4;
    localparam int AMAX = 16383;

    logic              clk, rst_n, x_valid, x_node, flush, result_ready;
    logic              x_ready, result_valid, busy;
    logic signed [6:0] xi [4];
    logic signed [6:0] xo [4];
    logic [12:0]       rl [4];
    logic [3:0]        out_rdy;
    logic [1:0]        dnn_state;
    logic signed [14:0] ag [8];

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  chk_en  = 0;
    int  w [4][4];
    int  exp_aggr [2][4];
    int  exp_cnt [2];
    int  exp_x [4];
    int  exp_dnn;
    bit  exp_busy, exp_rv;

    dnn_ctrl #(.SAMPLES_PER_NODE(S)) dut (
        .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x_ready(x_ready), .x_node(x_node),
        .x_in0(xi[0]), .x_in1(xi[1]), .x_in2(xi[2]), .x_in3(xi[3]), .flush(flush),
        .dnn_state(dnn_state), .x0(xo[0]), .x1(xo[1]), .x2(xo[2]), .x3(xo[3]),
        .y4_relu(rl[0]), .y5_relu(rl[1]), .y6_relu(rl[2]), .y7_relu(rl[3]),
        .out0_n0_ready(out_rdy[0]), .out0_n1_ready(out_rdy[1]),
        .out1_n0_ready(out_rdy[2]), .out1_n1_ready(out_rdy[3]),
        .y4_n0_aggr(ag[0]), .y5_n0_aggr(ag[1]), .y6_n0_aggr(ag[2]), .y7_n0_aggr(ag[3]),
        .y4_n1_aggr(ag[4]), .y5_n1_aggr(ag[5]), .y6_n1_aggr(ag[6]), .y7_n1_aggr(ag[7]),
        .result_valid(result_valid), .result_ready(result_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Every falling edge the DUT must agree with the model.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("busy", busy, exp_busy);
            chk("dnn_state", dnn_state, exp_dnn);
            chk("result_valid", result_valid, exp_rv);
            chk("x_ready", x_ready, (!exp_busy && exp_cnt[x_node] < S) ? 1 : 0);
            for (int i = 0; i < 4; i++) chk($sformatf("x%0d", i), xo[i], exp_x[i]);
            for (int n = 0; n < 2; n++)
                for (int k = 0; k < 4; k++)
                    chk($sformatf("y%0d_n%0d_aggr", k + 4, n), ag[n*4+k], exp_aggr[n][k]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_accum();
        for (int n = 0; n < 2; n++) begin
            exp_cnt[n] = 0;
            for (int k = 0; k < 4; k++) exp_aggr[n][k] = 0;
        end
    endtask

    task automatic model_reset();
        exp_busy = 0; exp_rv = 0; exp_dnn = 0;
        for (int i = 0; i < 4; i++) exp_x[i] = 0;
        clear_accum();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_dnn_state"}, dnn_state, 0);
        chk({tag, "_result_valid"}, result_valid, 0);
        for (int i = 0; i < 4; i++) chk($sformatf("%s_x%0d", tag, i), xo[i], 0);
        for (int j = 0; j < 8; j++) chk($sformatf("%s_aggr%0d", tag, j), ag[j], 0);
    endtask

    task automatic apply_reset_now(input string tag);
        #2 rst_n = 1'b0;
        #1 chk_reset(tag);
        x_valid = 0; flush = 0; result_ready = 0; out_rdy = 4'hF;
        model_reset();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic set_weights(input int sel);
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) w[i][k] = 0;
        if (sel == 1) begin
            for (int i = 0; i < 4; i++) w[i][0] = 1;
            w[0][1] = 1; w[0][2] = 1; w[0][3] = 1;
        end else if (sel == 2) begin
            w[0][0] = 1;
        end else begin
            w[0][0] = 130;
        end
    endtask

    // Offer one vector; the datapath ReLU results come from the bench's own weights.
    task automatic send_vec(input int node, input int a, input int b, input int c, input int d,
                            input bit fl);
        int v [4];
        int s;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int k = 0; k < 4; k++) begin
            s = 0;
            for (int i = 0; i < 4; i++) s += v[i] * w[i][k];
            rl[k] = (s < 0) ? 13'd0 : 13'(s);
        end
        for (int i = 0; i < 4; i++) xi[i] = 7'(v[i]);
        x_node = node[0]; x_valid = 1; flush = fl;
        step();
        x_valid = 0; flush = 0;
        exp_busy = 1; exp_dnn = 1;
        for (int i = 0; i < 4; i++) exp_x[i] = v[i];
        step();
        step();
        exp_busy = 0; exp_dnn = 0;
        for (int k = 0; k < 4; k++)
            exp_aggr[node][k] = (exp_aggr[node][k] + int'(rl[k]) > AMAX) ? AMAX
                                : exp_aggr[node][k] + int'(rl[k]);
        exp_cnt[node]++;
    endtask

    // Final pass from IDLE: FIN, LATCH (optionally stalled), DONE, then handshake or reset.
    task automatic final_pass(input bit use_flush, input int stall, input int hold, input bit rst_in_done);
        flush = use_flush;
        step();
        flush = 0; exp_busy = 1; exp_dnn = 2;
        out_rdy = (stall > 0) ? 4'b1011 : 4'b1111;
        step();
        exp_dnn = 0;
        for (int i = 0; i < stall; i++) step();
        out_rdy = 4'hF;
        step();
        exp_rv = 1;
        if (rst_in_done) begin
            chk("done_result_valid", result_valid, 1);
            apply_reset_now("rst_done");
        end else begin
            x_node = 0; x_valid = 1; flush = 1;
            for (int i = 0; i < hold; i++) step();
            x_valid = 0; flush = 0; result_ready = 1;
            step();
            result_ready = 0; exp_rv = 0; exp_busy = 0;
            clear_accum();
        end
    endtask

    initial begin
        rst_n = 0; x_valid = 0; x_node = 0; flush = 0; result_ready = 0; out_rdy = 4'hF;
        for (int i = 0; i < 4; i++) begin xi[i] = 0; rl[i] = 0; end
        model_reset();
        set_weights(1);
        step();
        step();
        chk_reset("por");
        rst_n = 1; chk_en = 1;
        step();

        // Interleaved nodes; first vector also carries flush to show the transfer wins.
        send_vec(0, 1, 1, 1, 1, 1'b1);
        send_vec(1, 2, 0, 0, 0, 1'b0);
        send_vec(0, 1, 1, 1, 1, 1'b0);
        send_vec(1, 2, 0, 0, 0, 1'b0);
        send_vec(0, 1, 1, 1, 1, 1'b0);
        send_vec(1, 2, 0, 0, 0, 1'b0);
        send_vec(0, 1, 1, 1, 1, 1'b0);
        send_vec(1, 2, 0, 0, 0, 1'b0);
        chk("lit_y4_n0", ag[0], 16);
        chk("lit_y5_n0", ag[1], 4);
        chk("lit_y4_n1", ag[4], 8);
        chk("lit_y7_n1", ag[7], 8);
        final_pass(1'b0, 3, 2, 1'b0);

        // Negative layer-1 sum contributes nothing but still counts.
        set_weights(2);
        send_vec(0, -5, 0, 0, 0, 1'b0);
        chk("lit_neg_y4", ag[0], 0);
        send_vec(0, 3, 0, 0, 0, 1'b0);
        chk("lit_pos_y4", ag[0], 3);
        final_pass(1'b1, 0, 0, 1'b0);

        // Saturation at +16383.
        set_weights(3);
        send_vec(0, 63, 0, 0, 0, 1'b0);
        send_vec(0, 63, 0, 0, 0, 1'b0);
        chk("lit_sum2", ag[0], 16380);
        send_vec(0, 63, 0, 0, 0, 1'b0);
        chk("lit_sat3", ag[0], 16383);
        send_vec(0, 63, 0, 0, 0, 1'b0);
        chk("lit_sat4", ag[0], 16383);

        // Node0 full: refused; node1 still accepted.
        set_weights(1);
        x_node = 0; x_valid = 1;
        chk("lit_xready_full", x_ready, 0);
        step();
        step();
        x_valid = 0;
        send_vec(1, 1, 0, 0, 0, 1'b0);
        chk("lit_n1_accepted", ag[4], 1);
        final_pass(1'b1, 0, 1, 1'b0);

        // Flush after one vector, result held 10 cycles.
        send_vec(0, 2, 1, 0, 0, 1'b0);
        final_pass(1'b1, 0, 10, 1'b0);
        chk("lit_cleared_y4", ag[0], 0);

        // Reset during CAPT.
        send_vec(1, 3, 3, 0, 0, 1'b0);
        xi[0] = 7'sd5; xi[1] = 0; xi[2] = 0; xi[3] = 0;
        x_node = 0; x_valid = 1;
        step();
        x_valid = 0;
        exp_busy = 1; exp_dnn = 1; exp_x[0] = 5; exp_x[1] = 0;
        step();
        apply_reset_now("rst_capt");
        step();

        // Reset during DONE.
        send_vec(0, 1, 1, 1, 1, 1'b0);
        final_pass(1'b1, 0, 0, 1'b1);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
